// File: rtl/multi_bram_readout_if.sv
// BRAM-side bus of multi_bram_readout: shared read address, per-channel
// freeze strobes and the concatenated read data of all channel BRAMs.
// The readout engine is the master; the BRAM/camera side is the slave.
interface multi_bram_readout_if #(
  parameter int NUM_CH     = 2,
  parameter int BRAM_WIDTH = 48,
  parameter int BRAM_DEPTH = 12800
);
  localparam int IDX_W = (BRAM_DEPTH > 1) ? $clog2(BRAM_DEPTH) : 1;

  logic [NUM_CH*BRAM_WIDTH-1:0] data_in;
  logic [IDX_W-1:0]             req_index_out;
  logic [NUM_CH-1:0]            freeze_out;

  modport master (
    input  data_in,
    output req_index_out,
    output freeze_out
  );

  modport slave (
    output data_in,
    input  req_index_out,
    input  freeze_out
  );
endinterface

// File: rtl/multi_bram_readout.sv
// multi_bram_readout: dumps the selected frame BRAM channels over one 8N1
// UART line. Per channel: 0xA5, channel index, then every word LSB byte
// first; a single 0x5A closes the dump. Masked channels have their camera
// writes frozen until their last data byte has left the line.
// Optional build macro CHECKSUM_EN: appends an XOR byte of each channel's
// data bytes after that channel's final data byte.
module multi_bram_readout #(
  parameter int NUM_CH     = 2,
  parameter int BRAM_WIDTH = 48,
  parameter int BRAM_DEPTH = 12800,
  parameter int CLK_FREQ   = 74250000,
  parameter int BAUD_RATE  = 2970000
) (
  input  logic              clk_in,
  input  logic              rst_in_n,
  input  logic              send_data_in,
  input  logic [NUM_CH-1:0] ch_mask_in,
  output logic              busy_out,
  output logic              uart_txd,
  multi_bram_readout_if.master bram
);

  localparam int CLKS_PER_BAUD  = CLK_FREQ / BAUD_RATE;
  localparam int BAUD_W         = $clog2(CLKS_PER_BAUD);
  localparam int BYTES_PER_WORD = (BRAM_WIDTH + 7) / 8;
  localparam int WORD_W         = BYTES_PER_WORD * 8;
  localparam int IDX_W          = (BRAM_DEPTH > 1) ? $clog2(BRAM_DEPTH) : 1;
  localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BI_W           = $clog2(BYTES_PER_WORD + 3);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BRAM_DEPTH - 1);
  localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLKS_PER_BAUD - 1);
  localparam logic [7:0]        HDR_BYTE  = 8'hA5;
  localparam logic [7:0]        TERM_BYTE = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_FETCH  = 3'd2,
    ST_SEND   = 3'd3,
    ST_NEXTCH = 3'd4,
    ST_TERM   = 3'd5
`ifdef CHECKSUM_EN
    , ST_CHK  = 3'd6
`endif
  } state_t;

  // Lowest set bit of a channel mask; channels are dumped in ascending order.
  function automatic logic [CH_W-1:0] first_set(input logic [NUM_CH-1:0] m);
    logic [CH_W-1:0] r;
    r = {CH_W{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) begin
        r = CH_W'(i);
      end
    end
    return r;
  endfunction

  state_t              state_q, state_d;
  logic                send_s1_q, send_s2_q;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_CH-1:0]   freeze_q, freeze_d;
  logic                busy_q, busy_d;
  logic [1:0]          fetch_cnt_q, fetch_cnt_d;
  logic [BI_W-1:0]     byte_idx_q, byte_idx_d;
  logic [WORD_W-1:0]   word_q, word_d;
`ifdef CHECKSUM_EN
  logic [7:0]          acc_q, acc_d;
`endif

  // UART transmitter state: frame_q[0] drives the line directly.
  logic [9:0]          frame_q, frame_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
  logic                tx_active_q, tx_active_d;

  logic                tx_start_s;
  logic [7:0]          tx_byte_s;
  logic                tx_last_s;
  logic                tx_ready_s;
  logic                rise_s;
  logic [NUM_CH-1:0]   ch_onehot_s;
  logic [WORD_W-1:0]   word_wide_s;
  logic [7:0]          word_byte_s;

  // Last cycle of a stop bit; a new byte issued here follows back to back.
  assign tx_last_s   = tx_active_q && (bit_cnt_q == 4'd9) && (baud_cnt_q == LAST_BAUD);
  assign tx_ready_s  = !tx_active_q || tx_last_s;
  assign rise_s      = send_s1_q && !send_s2_q;
  assign ch_onehot_s = NUM_CH'(1) << ch_q;
  assign word_wide_s = WORD_W'(bram.data_in[ch_q*BRAM_WIDTH +: BRAM_WIDTH]);
  assign word_byte_s = word_q[{byte_idx_q, 3'b000} +: 8];

  assign busy_out           = busy_q;
  assign uart_txd           = frame_q[0];
  assign bram.req_index_out = idx_q;
  assign bram.freeze_out    = freeze_q;

  // Dump sequencer: next state, channel/index bookkeeping and byte issue.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    ch_d        = ch_q;
    idx_d       = idx_q;
    freeze_d    = freeze_q;
    busy_d      = busy_q;
    fetch_cnt_d = fetch_cnt_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    tx_start_s  = 1'b0;
    tx_byte_s   = 8'h00;
`ifdef CHECKSUM_EN
    acc_d       = acc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rise_s && (ch_mask_in != {NUM_CH{1'b0}})) begin
          mask_d     = ch_mask_in;
          ch_d       = first_set(ch_mask_in);
          freeze_d   = ch_mask_in;
          busy_d     = 1'b1;
          idx_d      = {IDX_W{1'b0}};
          byte_idx_d = {BI_W{1'b0}};
`ifdef CHECKSUM_EN
          acc_d      = 8'h00;
`endif
          state_d    = ST_HDR;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (byte_idx_q < BI_W'(2)) begin
          if (tx_ready_s) begin
            tx_start_s = 1'b1;
            tx_byte_s  = (byte_idx_q == {BI_W{1'b0}}) ? HDR_BYTE : 8'(ch_q);
            byte_idx_d = byte_idx_q + BI_W'(1);
          end else begin
            byte_idx_d = byte_idx_q;
          end
        end else if (tx_last_s) begin
          byte_idx_d  = {BI_W{1'b0}};
          fetch_cnt_d = 2'd0;
          state_d     = ST_FETCH;
        end else begin
          state_d     = ST_HDR;
        end
      end
      ST_FETCH: begin
        // Two cycles of BRAM latency; the word is valid on the third and its
        // first byte goes out immediately so the line idles only in FETCH.
        if (fetch_cnt_q == 2'd2) begin
          word_d      = word_wide_s;
          tx_start_s  = 1'b1;
          tx_byte_s   = word_wide_s[7:0];
`ifdef CHECKSUM_EN
          acc_d       = acc_q ^ word_wide_s[7:0];
`endif
          byte_idx_d  = BI_W'(1);
          fetch_cnt_d = 2'd0;
          state_d     = ST_SEND;
        end else begin
          fetch_cnt_d = fetch_cnt_q + 2'd1;
        end
      end
      ST_SEND: begin
        if (byte_idx_q < BI_W'(BYTES_PER_WORD)) begin
          if (tx_ready_s) begin
            tx_start_s = 1'b1;
            tx_byte_s  = word_byte_s;
`ifdef CHECKSUM_EN
            acc_d      = acc_q ^ word_byte_s;
`endif
            byte_idx_d = byte_idx_q + BI_W'(1);
          end else begin
            byte_idx_d = byte_idx_q;
          end
        end else if (tx_last_s) begin
          byte_idx_d = {BI_W{1'b0}};
          if (idx_q == LAST_IDX) begin
            idx_d      = {IDX_W{1'b0}};
`ifdef CHECKSUM_EN
            tx_start_s = 1'b1;
            tx_byte_s  = acc_q;
            state_d    = ST_CHK;
`else
            freeze_d   = freeze_q & ~ch_onehot_s;
            mask_d     = mask_q & ~ch_onehot_s;
            state_d    = ST_NEXTCH;
`endif
          end else begin
            idx_d       = idx_q + IDX_W'(1);
            fetch_cnt_d = 2'd0;
            state_d     = ST_FETCH;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
`ifdef CHECKSUM_EN
      ST_CHK: begin
        if (tx_last_s) begin
          freeze_d = freeze_q & ~ch_onehot_s;
          mask_d   = mask_q & ~ch_onehot_s;
          state_d  = ST_NEXTCH;
        end else begin
          state_d  = ST_CHK;
        end
      end
`endif
      ST_NEXTCH: begin
        byte_idx_d = {BI_W{1'b0}};
        if (mask_q != {NUM_CH{1'b0}}) begin
          ch_d    = first_set(mask_q);
`ifdef CHECKSUM_EN
          acc_d   = 8'h00;
`endif
          state_d = ST_HDR;
        end else begin
          state_d = ST_TERM;
        end
      end
      ST_TERM: begin
        if (byte_idx_q == {BI_W{1'b0}}) begin
          if (tx_ready_s) begin
            tx_start_s = 1'b1;
            tx_byte_s  = TERM_BYTE;
            byte_idx_d = BI_W'(1);
          end else begin
            byte_idx_d = byte_idx_q;
          end
        end else if (tx_last_s) begin
          busy_d     = 1'b0;
          byte_idx_d = {BI_W{1'b0}};
          state_d    = ST_IDLE;
        end else begin
          state_d    = ST_TERM;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // UART shifter: start bit, 8 data bits LSB first, stop bit, CLKS_PER_BAUD each.
  always_comb begin
    frame_d     = frame_q;
    bit_cnt_d   = bit_cnt_q;
    baud_cnt_d  = baud_cnt_q;
    tx_active_d = tx_active_q;
    if (tx_start_s) begin
      frame_d     = {1'b1, tx_byte_s, 1'b0};
      bit_cnt_d   = 4'd0;
      baud_cnt_d  = {BAUD_W{1'b0}};
      tx_active_d = 1'b1;
    end else if (tx_active_q) begin
      if (baud_cnt_q == LAST_BAUD) begin
        baud_cnt_d = {BAUD_W{1'b0}};
        if (bit_cnt_q == 4'd9) begin
          tx_active_d = 1'b0;
          frame_d     = {10{1'b1}};
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          frame_d   = {1'b1, frame_q[9:1]};
        end
      end else begin
        baud_cnt_d = baud_cnt_q + BAUD_W'(1);
      end
    end else begin
      frame_d = {10{1'b1}};
    end
  end

  // State and datapath registers; reset returns the line to idle-high at once.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q     <= ST_IDLE;
      send_s1_q   <= 1'b1;
      send_s2_q   <= 1'b1;
      mask_q      <= {NUM_CH{1'b0}};
      ch_q        <= {CH_W{1'b0}};
      idx_q       <= {IDX_W{1'b0}};
      freeze_q    <= {NUM_CH{1'b0}};
      busy_q      <= 1'b0;
      fetch_cnt_q <= 2'd0;
      byte_idx_q  <= {BI_W{1'b0}};
      word_q      <= {WORD_W{1'b0}};
`ifdef CHECKSUM_EN
      acc_q       <= 8'h00;
`endif
      frame_q     <= {10{1'b1}};
      bit_cnt_q   <= 4'd0;
      baud_cnt_q  <= {BAUD_W{1'b0}};
      tx_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      send_s1_q   <= send_data_in;
      send_s2_q   <= send_s1_q;
      mask_q      <= mask_d;
      ch_q        <= ch_d;
      idx_q       <= idx_d;
      freeze_q    <= freeze_d;
      busy_q      <= busy_d;
      fetch_cnt_q <= fetch_cnt_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
`ifdef CHECKSUM_EN
      acc_q       <= acc_d;
`endif
      frame_q     <= frame_d;
      bit_cnt_q   <= bit_cnt_d;
      baud_cnt_q  <= baud_cnt_d;
      tx_active_q <= tx_active_d;
    end
  end

endmodule

// File: tb/tb_multi_bram_readout.sv
// Testbench for multi_bram_readout: a cycle-accurate UART receiver feeds a
// scoreboard whose expected bytes, gaps, freeze and busy values come from a
// stream model built from the dump rules and the BRAM contents.
module tb_multi_bram_readout;
  localparam int NCH = 2;
  localparam int W   = 12;
  localparam int D   = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           send = 1'b0;
  logic [NCH-1:0] mask = 2'b00;
  logic           busy;
  logic           txd;

  multi_bram_readout_if #(.NUM_CH(NCH), .BRAM_WIDTH(W), .BRAM_DEPTH(D)) bram_if ();

  multi_bram_readout #(
    .NUM_CH(NCH), .BRAM_WIDTH(W), .BRAM_DEPTH(D), .CLK_FREQ(10), .BAUD_RATE(1)
  ) dut (
    .clk_in(clk), .rst_in_n(rst_n), .send_data_in(send), .ch_mask_in(mask),
    .busy_out(busy), .uart_txd(txd), .bram(bram_if)
  );

  always #5 clk = ~clk;

  // BRAM model with two cycles of read latency.
  logic [W-1:0]     mem [NCH][D];
  logic [NCH*W-1:0] rd1, rd2;
  always @(posedge clk) begin
    rd1 <= {mem[1][bram_if.req_index_out], mem[0][bram_if.req_index_out]};
    rd2 <= rd1;
  end
  assign bram_if.data_in = rd2;

  typedef struct {
    logic [7:0]     b;
    int             gap;       // -1: not checked
    logic [NCH-1:0] frz;
    logic [NCH-1:0] frz_after;
    logic           busy_after;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic check(input string name, input longint act, input longint req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [7:0] b, input int gap, input logic [NCH-1:0] frz,
                      input logic [NCH-1:0] frz_after, input logic busy_after);
    exp_t e;
    e.b = b; e.gap = gap; e.frz = frz; e.frz_after = frz_after; e.busy_after = busy_after;
    exp_q.push_back(e);
  endtask

  // Expected byte stream of one dump, straight from the framing rules.
  task automatic build_expected(input logic [NCH-1:0] m);
    logic [NCH-1:0] rem;
    logic [NCH-1:0] after_last;
    logic [7:0]     x;
    logic [7:0]     lo, hi;
    rem = m;
    for (int c = 0; c < NCH; c++) begin
      if (m[c]) begin
        after_last = rem & ~(NCH'(1) << c);
        push(8'hA5, -1, rem, rem, 1'b1);
        push(8'(c), 0, rem, rem, 1'b1);
        x = 8'h00;
        for (int k = 0; k < D; k++) begin
          lo = mem[c][k][7:0];
          hi = {4'h0, mem[c][k][11:8]};
          x = x ^ lo ^ hi;
          push(lo, 3, rem, rem, 1'b1);
`ifdef CHECKSUM_EN
          push(hi, 0, rem, rem, 1'b1);
`else
          push(hi, 0, rem, (k == D - 1) ? after_last : rem, 1'b1);
`endif
        end
`ifdef CHECKSUM_EN
        push(x, 0, rem, after_last, 1'b1);
`endif
        rem = after_last;
      end
    end
    push(8'h5A, -1, 2'b00, 2'b00, 1'b0);
  endtask

  // Cycle-accurate receiver / scoreboard monitor (samples on negedge).
  bit             rx_active = 1'b0;
  int             rx_cnt = 0;
  logic [9:0]     rx_bits;
  bit             rx_bad;
  int             gap_cnt = 0;
  int             cur_gap;
  logic [NCH-1:0] cur_frz;
  int             rx_total = 0;
  bit             pend_after = 1'b0;
  exp_t           pend;
  exp_t           e_cur;
  int             idx_viol = 0;
  int             bsel;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rx_active  = 1'b0;
        gap_cnt    = 0;
        pend_after = 1'b0;
      end else begin
        if (bram_if.req_index_out > 2'(D - 1)) idx_viol++;
        if (pend_after) begin
          pend_after = 1'b0;
          check("freeze_after_byte", bram_if.freeze_out, pend.frz_after);
          check("busy_after_byte", busy, pend.busy_after);
        end
        if (!rx_active) begin
          if (txd == 1'b0) begin
            rx_active = 1'b1;
            rx_cnt    = 1;
            rx_bits   = 10'h3FF;
            rx_bits[0] = 1'b0;
            rx_bad    = 1'b0;
            cur_gap   = gap_cnt;
            cur_frz   = bram_if.freeze_out;
          end else begin
            gap_cnt++;
          end
        end else begin
          bsel = rx_cnt / 10;
          if (rx_cnt % 10 == 0) rx_bits[bsel] = txd;
          else if (txd !== rx_bits[bsel]) rx_bad = 1'b1;
          rx_cnt++;
          if (rx_cnt == 100) begin
            rx_active = 1'b0;
            gap_cnt   = 0;
            rx_total++;
            check("bit_width_10clk", rx_bad, 0);
            check("stop_bit", rx_bits[9], 1);
            check("byte_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              e_cur = exp_q.pop_front();
              check("byte_value", rx_bits[8:1], e_cur.b);
              if (e_cur.gap >= 0) check("idle_gap", cur_gap, e_cur.gap);
              check("freeze_during_byte", cur_frz, e_cur.frz);
              pend       = e_cur;
              pend_after = 1'b1;
            end
          end
        end
      end
    end
  end

  // One dump: push expectations, pulse send, optionally re-pulse mid-dump.
  task automatic do_dump(input logic [NCH-1:0] m, input bit repulse);
    int n;
    build_expected(m);
    mask = m;
    @(negedge clk);
    send = 1'b1;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    send = 1'b0;
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    check("busy_rises", busy, 1);
    if (repulse) begin
      repeat (300) @(negedge clk);
      mask = 2'($urandom_range(0, 3));
      send = 1'b1;
      repeat (3) @(negedge clk);
      send = 1'b0;
    end
    n = 0;
    while (busy && n < 8000) begin @(negedge clk); n++; end
    check("busy_falls", busy, 0);
    repeat (10) @(negedge clk);
    check("stream_complete", exp_q.size(), 0);
  endtask

  task automatic fixed_mem();
    for (int k = 0; k < D; k++) begin
      mem[0][k] = 12'(12'h100 + k);
      mem[1][k] = 12'(12'hA00 + k);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    fixed_mem();
    // Reset held with send already high.
    send = 1'b1;
    mask = 2'b01;
    repeat (4) @(negedge clk);
    check("reset_txd", txd, 1);
    check("reset_busy", busy, 0);
    check("reset_freeze", bram_if.freeze_out, 0);
    check("reset_index", bram_if.req_index_out, 0);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("no_dump_level_high", busy, 0);
    send = 1'b0;
    repeat (5) @(negedge clk);

    // Zero mask edge is ignored.
    mask = 2'b00;
    send = 1'b1;
    repeat (3) @(negedge clk);
    send = 1'b0;
    repeat (60) @(negedge clk);
    check("no_dump_zero_mask", busy, 0);
    check("no_bytes_when_idle", rx_total, 0);

    // Single channel, dual channel, re-pulse during a dump.
    do_dump(2'b01, 1'b0);
    do_dump(2'b11, 1'b0);
    do_dump(2'b11, 1'b1);

    // Reset during the third byte's data bits.
    build_expected(2'b01);
    base = rx_total;
    mask = 2'b01;
    send = 1'b1;
    repeat (2) @(negedge clk);
    send = 1'b0;
    n = 0;
    while (!(rx_total == base + 2 && rx_active && rx_cnt == 35) && n < 2000) begin
      @(negedge clk); n++;
    end
    check("reached_third_byte", n < 2000, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_txd", txd, 1);
    check("async_reset_busy", busy, 0);
    check("async_reset_freeze", bram_if.freeze_out, 0);
    check("async_reset_index", bram_if.req_index_out, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    do_dump(2'b01, 1'b0);

    // Randomised contents and masks.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < D; k++)
          mem[c][k] = 12'($urandom);
      do_dump(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
    end

    check("index_in_range", idx_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
